// File: rtl/elevator_ctrl_scan.sv
// Single-car elevator controller: latches floor calls and serves them in SCAN
// order, with timed floor travel, timed door dwell and an emergency stop.
module elevator_ctrl_scan #(
    parameter  int NUM_FLOORS    = 8,
    parameter  int TRAVEL_CYCLES = 4,
    parameter  int DOOR_CYCLES   = 5,
    localparam int FLOOR_W       = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  emergency_stop,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up
);

    localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        EMERG
    } state_t;

    state_t                state;
    logic [TRAVEL_W-1:0]   travel_cnt;
    logic [DOOR_W-1:0]     door_timer;

    logic [FLOOR_W-1:0]    floor_up;
    logic [FLOOR_W-1:0]    floor_dn;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] up_mask;
    logic [NUM_FLOORS-1:0] dn_mask;
    logic [NUM_FLOORS-1:0] latched;
    logic                  at_top;
    logic                  at_bottom;
    logic                  travel_done;
    logic                  pend_cur;
    logic                  pend_up;
    logic                  pend_dn;
    logic                  above_cur;
    logic                  below_cur;
    logic                  above_up;
    logic                  below_dn;
    logic                  recall;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (i > int'(f))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (i < int'(f))) hit = 1'b1;
        end
        return hit;
    endfunction

    // Neighbour floors and their masks let an arrival decide on the new floor
    // in the same edge that updates current_floor.
    assign floor_up    = current_floor + 1'b1;
    assign floor_dn    = current_floor - 1'b1;
    assign cur_mask    = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << current_floor;
    assign up_mask     = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor_up;
    assign dn_mask     = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << floor_dn;
    assign latched     = pending | call_req;
    assign at_top      = (current_floor == FLOOR_W'(NUM_FLOORS - 1));
    assign at_bottom   = (current_floor == '0);
    assign travel_done = (travel_cnt == TRAVEL_W'(TRAVEL_CYCLES - 1));
    assign pend_cur    = |(pending & cur_mask);
    assign pend_up     = |(pending & up_mask);
    assign pend_dn     = |(pending & dn_mask);
    assign above_cur   = any_above(pending, current_floor);
    assign below_cur   = any_below(pending, current_floor);
    assign above_up    = any_above(pending, floor_up);
    assign below_dn    = any_below(pending, floor_dn);
    assign recall      = |(call_req & cur_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            travel_cnt    <= '0;
            door_timer    <= '0;
            door_open     <= 1'b0;
            motor_up      <= 1'b0;
            motor_down    <= 1'b0;
        end else begin
            // NOTE: these defaults are overridden by later non-blocking
            // assignments in the same edge; the last one scheduled wins.
            door_open  <= 1'b0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            pending    <= latched;

            if (emergency_stop) begin
                state      <= EMERG;
                door_open  <= 1'b1;
                travel_cnt <= '0;
                door_timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pend_cur) begin
                            state      <= DOOR_OPEN;
                            door_open  <= 1'b1;
                            door_timer <= DOOR_W'(DOOR_CYCLES);
                            pending    <= latched & ~cur_mask;
                        end else if (above_cur && (dir_up || !below_cur)) begin
                            state      <= MOVE_UP;
                            dir_up     <= 1'b1;
                            motor_up   <= 1'b1;
                            travel_cnt <= '0;
                        end else if (below_cur) begin
                            state      <= MOVE_DOWN;
                            dir_up     <= 1'b0;
                            motor_down <= 1'b1;
                            travel_cnt <= '0;
                        end
                    end

                    MOVE_UP: begin
                        if (at_top) begin
                            state      <= IDLE;
                            travel_cnt <= '0;
                        end else if (!travel_done) begin
                            travel_cnt <= travel_cnt + 1'b1;
                            motor_up   <= 1'b1;
                        end else begin
                            travel_cnt    <= '0;
                            current_floor <= floor_up;
                            if (pend_up) begin
                                state      <= DOOR_OPEN;
                                door_open  <= 1'b1;
                                door_timer <= DOOR_W'(DOOR_CYCLES);
                                pending    <= latched & ~up_mask;
                            end else if (above_up) begin
                                motor_up <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end

                    MOVE_DOWN: begin
                        if (at_bottom) begin
                            state      <= IDLE;
                            travel_cnt <= '0;
                        end else if (!travel_done) begin
                            travel_cnt <= travel_cnt + 1'b1;
                            motor_down <= 1'b1;
                        end else begin
                            travel_cnt    <= '0;
                            current_floor <= floor_dn;
                            if (pend_dn) begin
                                state      <= DOOR_OPEN;
                                door_open  <= 1'b1;
                                door_timer <= DOOR_W'(DOOR_CYCLES);
                                pending    <= latched & ~dn_mask;
                            end else if (below_dn) begin
                                motor_down <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end

                    DOOR_OPEN: begin
                        // A call for this floor keeps the door open instead of latching.
                        pending   <= latched & ~cur_mask;
                        door_open <= 1'b1;
                        if (recall) begin
                            door_timer <= DOOR_W'(DOOR_CYCLES);
                        end else if (door_timer <= DOOR_W'(1)) begin
                            state      <= IDLE;
                            door_open  <= 1'b0;
                            door_timer <= '0;
                        end else begin
                            door_timer <= door_timer - 1'b1;
                        end
                    end

                    EMERG: begin
                        state      <= DOOR_OPEN;
                        door_open  <= 1'b1;
                        door_timer <= DOOR_W'(DOOR_CYCLES);
                        pending    <= latched & ~cur_mask;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// Directed bench for elevator_ctrl_scan with 8 floors, 4-cycle travel and
// 5-cycle door dwell; expected values are hand-derived edge by edge.
module tb_elevator_ctrl_scan;

    logic       clk;
    logic       reset;
    logic       emergency_stop;
    logic [7:0] call_req;
    logic [2:0] current_floor;
    logic       door_open;
    logic       motor_up;
    logic       motor_down;
    logic [7:0] pending;
    logic       dir_up;

    int vectors     = 0;
    int miscompares = 0;

    elevator_ctrl_scan #(
        .NUM_FLOORS   (8),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .emergency_stop(emergency_stop),
        .call_req      (call_req),
        .current_floor (current_floor),
        .door_open     (door_open),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .pending       (pending),
        .dir_up        (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Outputs must never show overlapping motor/door activity.
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if ((motor_up && motor_down) || (door_open && (motor_up || motor_down))) begin
                miscompares++;
                $display("FAIL exclusive_outputs: door=%b up=%b down=%b, required no overlap",
                         door_open, motor_up, motor_down);
            end
        end
    end

    // {door_open, motor_up, motor_down, dir_up, current_floor}
    function automatic logic [6:0] obs();
        return {door_open, motor_up, motor_down, dir_up, current_floor};
    endfunction

    function automatic logic [6:0] st(input logic d, input logic u, input logic m,
                                      input logic dir, input int f);
        return {d, u, m, dir, 3'(f)};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        call_req       = '0;
        emergency_stop = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse_call(input logic [7:0] c);
        call_req = c;
        tick(1);
        call_req = '0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        call_req       = '0;
        emergency_stop = 1'b0;
        tick(2);
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL reset_state: got %b required %b", obs(), st(0, 0, 0, 1, 0));
        end
        vectors++;
        if (pending !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pending: got %b required %b", pending, 8'h00);
        end
        reset = 1'b0;
        tick(1);
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL reset_idle_after: got %b required %b", obs(), st(0, 0, 0, 1, 0));
        end
        // Mid-move reset: call floor 5, car leaves floor 0, then reset.
        pulse_call(8'b0010_0000);          // edge 0
        tick(7);                           // after edge 7: floor 1, moving up
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL reset_pre_move: got %b required %b", obs(), st(0, 1, 0, 1, 1));
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 0) || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_move: got %b/%b required %b/%b",
                     obs(), pending, st(0, 0, 0, 1, 0), 8'h00);
        end
    endtask

    task automatic test_single_call();
        do_reset();
        pulse_call(8'b0000_0100);          // edge 0
        vectors++;
        if (pending !== 8'b0000_0100 || obs() !== st(0, 0, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL single_latch: got %b/%b required %b/%b",
                     pending, obs(), 8'b0000_0100, st(0, 0, 0, 1, 0));
        end
        tick(1);                           // edge 1
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL single_start: got %b required %b", obs(), st(0, 1, 0, 1, 0));
        end
        tick(3);                           // edge 4
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL single_travel_hold: got %b required %b", obs(), st(0, 1, 0, 1, 0));
        end
        tick(1);                           // edge 5
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL single_floor1: got %b required %b", obs(), st(0, 1, 0, 1, 1));
        end
        tick(4);                           // edge 9
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 2) || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL single_arrive: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 1, 2), 8'h00);
        end
        tick(4);                           // edge 13
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 2)) begin
            miscompares++;
            $display("FAIL single_dwell_last: got %b required %b", obs(), st(1, 0, 0, 1, 2));
        end
        tick(1);                           // edge 14
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 2)) begin
            miscompares++;
            $display("FAIL single_close: got %b required %b", obs(), st(0, 0, 0, 1, 2));
        end
    endtask

    task automatic test_scan_reverse();
        do_reset();
        pulse_call(8'b0100_0000);          // edge 0
        tick(17);                          // edge 17: arrives at 4, keeps going
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 4)) begin
            miscompares++;
            $display("FAIL scan_at4: got %b required %b", obs(), st(0, 1, 0, 1, 4));
        end
        pulse_call(8'b0000_0010);          // edge 18
        vectors++;
        if (pending !== 8'b0100_0010 || obs() !== st(0, 1, 0, 1, 4)) begin
            miscompares++;
            $display("FAIL scan_latch: got %b/%b required %b/%b",
                     pending, obs(), 8'b0100_0010, st(0, 1, 0, 1, 4));
        end
        tick(7);                           // edge 25
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 6) || pending !== 8'b0000_0010) begin
            miscompares++;
            $display("FAIL scan_serve6: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 1, 6), 8'b0000_0010);
        end
        tick(5);                           // edge 30
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 6)) begin
            miscompares++;
            $display("FAIL scan_close6: got %b required %b", obs(), st(0, 0, 0, 1, 6));
        end
        tick(1);                           // edge 31
        vectors++;
        if (obs() !== st(0, 0, 1, 0, 6)) begin
            miscompares++;
            $display("FAIL scan_reverse: got %b required %b", obs(), st(0, 0, 1, 0, 6));
        end
        tick(20);                          // edge 51
        vectors++;
        if (obs() !== st(1, 0, 0, 0, 1) || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL scan_serve1: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 0, 1), 8'h00);
        end
        tick(5);                           // edge 56
        vectors++;
        if (obs() !== st(0, 0, 0, 0, 1)) begin
            miscompares++;
            $display("FAIL scan_close1: got %b required %b", obs(), st(0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_emergency();
        do_reset();
        pulse_call(8'b0000_0100);          // edge 0
        tick(6);                           // edge 6: first cycle of 1 -> 2
        emergency_stop = 1'b1;
        tick(1);                           // edge 7
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL emerg_enter: got %b required %b", obs(), st(1, 0, 0, 1, 1));
        end
        pulse_call(8'b0000_0010);          // edge 8: current floor call latches
        vectors++;
        if (pending !== 8'b0000_0110) begin
            miscompares++;
            $display("FAIL emerg_latch: got %b required %b", pending, 8'b0000_0110);
        end
        tick(1);                           // edge 9: would have been arrival
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL emerg_hold: got %b required %b", obs(), st(1, 0, 0, 1, 1));
        end
        emergency_stop = 1'b0;
        tick(1);                           // edge 10: DOOR_OPEN
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 1) || pending !== 8'b0000_0100) begin
            miscompares++;
            $display("FAIL emerg_release: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 1, 1), 8'b0000_0100);
        end
        tick(5);                           // edge 15
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL emerg_dwell_end: got %b required %b", obs(), st(0, 0, 0, 1, 1));
        end
        tick(4);                           // edge 19: fresh travel, not yet there
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 1)) begin
            miscompares++;
            $display("FAIL emerg_resume: got %b required %b", obs(), st(0, 1, 0, 1, 1));
        end
        tick(1);                           // edge 20
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 2)) begin
            miscompares++;
            $display("FAIL emerg_arrive2: got %b required %b", obs(), st(1, 0, 0, 1, 2));
        end
    endtask

    task automatic test_door_recall();
        do_reset();
        pulse_call(8'b0000_1000);          // edge 0
        tick(13);                          // edge 13: door opens at 3
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 3)) begin
            miscompares++;
            $display("FAIL recall_open: got %b required %b", obs(), st(1, 0, 0, 1, 3));
        end
        tick(2);                           // edge 15
        pulse_call(8'b0000_1000);          // edge 16: reload
        vectors++;
        if (pending !== 8'h00 || obs() !== st(1, 0, 0, 1, 3)) begin
            miscompares++;
            $display("FAIL recall_no_latch: got %b/%b required %b/%b",
                     pending, obs(), 8'h00, st(1, 0, 0, 1, 3));
        end
        tick(2);                           // edge 18: original dwell would end here
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 3)) begin
            miscompares++;
            $display("FAIL recall_extended: got %b required %b", obs(), st(1, 0, 0, 1, 3));
        end
        tick(2);                           // edge 20
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 3)) begin
            miscompares++;
            $display("FAIL recall_last: got %b required %b", obs(), st(1, 0, 0, 1, 3));
        end
        tick(1);                           // edge 21
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 3) || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL recall_close: got %b/%b required %b/%b",
                     obs(), pending, st(0, 0, 0, 1, 3), 8'h00);
        end
        tick(1);                           // edge 22: no reopen
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 3)) begin
            miscompares++;
            $display("FAIL recall_no_reopen: got %b required %b", obs(), st(0, 0, 0, 1, 3));
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        pulse_call(8'b1000_0001);          // edge 0
        vectors++;
        if (pending !== 8'b1000_0001) begin
            miscompares++;
            $display("FAIL bound_latch: got %b required %b", pending, 8'b1000_0001);
        end
        tick(1);                           // edge 1: serve floor 0 first
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 0) || pending !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL bound_open0: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 1, 0), 8'b1000_0000);
        end
        tick(6);                           // edge 7
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL bound_leave0: got %b required %b", obs(), st(0, 1, 0, 1, 0));
        end
        tick(27);                          // edge 34
        vectors++;
        if (obs() !== st(0, 1, 0, 1, 6)) begin
            miscompares++;
            $display("FAIL bound_near7: got %b required %b", obs(), st(0, 1, 0, 1, 6));
        end
        tick(1);                           // edge 35
        vectors++;
        if (obs() !== st(1, 0, 0, 1, 7) || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL bound_arrive7: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 1, 7), 8'h00);
        end
        tick(10);                          // edge 45: parked, no overshoot
        vectors++;
        if (obs() !== st(0, 0, 0, 1, 7)) begin
            miscompares++;
            $display("FAIL bound_park7: got %b required %b", obs(), st(0, 0, 0, 1, 7));
        end
    endtask

    task automatic test_back_to_back();
        // Continues from floor 7: full run down to floor 0.
        pulse_call(8'b0000_0001);          // edge 46
        tick(1);                           // edge 47
        vectors++;
        if (obs() !== st(0, 0, 1, 0, 7)) begin
            miscompares++;
            $display("FAIL b2b_down: got %b required %b", obs(), st(0, 0, 1, 0, 7));
        end
        tick(28);                          // edge 75
        vectors++;
        if (obs() !== st(1, 0, 0, 0, 0) || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL b2b_arrive0: got %b/%b required %b/%b",
                     obs(), pending, st(1, 0, 0, 0, 0), 8'h00);
        end
        tick(10);                          // parked at 0
        vectors++;
        if (obs() !== st(0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL b2b_park0: got %b required %b", obs(), st(0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        reset          = 1'b1;
        emergency_stop = 1'b0;
        call_req       = '0;
        test_reset();
        test_single_call();
        test_scan_reverse();
        test_emergency();
        test_door_recall();
        test_boundaries();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
